// File: rtl/wb_trace_pkg.sv
// Shared types and parameter defaults for the writeback trace capture block.
package wb_trace_pkg;

  localparam int DEPTH_DEF        = 16;
  localparam int STOP_ON_FULL_DEF = 1;
  localparam int FILTER_R0_DEF    = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // 69-bit trace record: PC, destination register, written value.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// First-word fall-through trace FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  entry_t                   i_wdata,
  output entry_t                   o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push_ok;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop     = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop);

  // Head is masked while empty so stale storage never leaks out (including in reset).
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace.sv
// Processor writeback tracer: IDLE/CAPTURE/DONE control, R0 filtering, overflow
// and stall counters around a trace_fifo readout path.
module wb_trace
  import wb_trace_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int STOP_ON_FULL = STOP_ON_FULL_DEF,
  parameter int FILTER_R0    = FILTER_R0_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_en,
  input  logic [4:0]             wb_reg,
  input  logic [31:0]            wb_data,
  input  logic [31:0]            wb_pc,
  input  logic                   stall,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [31:0]            rd_pc,
  output logic [4:0]             rd_reg,
  output logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            stall_cycles,
  output logic                   busy
);

  state_t r_state;
  state_t w_next;
  logic   r_overflow;
  logic [15:0] r_stall_cycles;

  entry_t w_wentry;
  entry_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_capture;
  logic   w_drop;
  logic   w_start_go;

  assign w_start_go = start && !stop;
  assign w_capture  = (r_state == ST_CAPTURE) && wb_en &&
                      !((FILTER_R0 != 0) && (wb_reg == 5'd0));
  // Full FIFO only takes a push if the consumer frees a slot in the same edge.
  assign w_drop     = w_capture && w_full && !rd_ready;

  assign w_wentry.pc   = wb_pc;
  assign w_wentry.rg   = wb_reg;
  assign w_wentry.data = wb_data;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_capture),
    .i_pop   (rd_ready),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_go) w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (stop)                                w_next = ST_DONE;
        else if ((STOP_ON_FULL != 0) && w_full)  w_next = ST_DONE;
      end
      ST_DONE:    if (w_empty) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow     <= 1'b0;
      r_stall_cycles <= '0;
    end else if ((r_state == ST_IDLE) && w_start_go) begin
      r_overflow     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if ((r_state == ST_CAPTURE) && stall && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign rd_valid     = !w_empty;
  assign rd_pc        = w_head.pc;
  assign rd_reg       = w_head.rg;
  assign rd_data      = w_head.data;
  assign overflow     = r_overflow;
  assign stall_cycles = r_stall_cycles;
  assign busy         = (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_wb_trace.sv
// Directed bench for wb_trace with a queue scoreboard of expected FIFO entries.
module tb_wb_trace;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        stall;
  logic        start;
  logic        stop;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] stall_cycles;
  logic        busy;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  wb_trace #(
    .DEPTH        (16),
    .STOP_ON_FULL (1),
    .FILTER_R0    (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .wb_pc        (wb_pc),
    .stall        (stall),
    .start        (start),
    .stop         (stop),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_pc        (rd_pc),
    .rd_reg       (rd_reg),
    .rd_data      (rd_data),
    .count        (count),
    .overflow     (overflow),
    .stall_cycles (stall_cycles),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check model occupancy, score any pop, record any expected push.
  task automatic tick(input bit exp_push);
    exp_t e;
    chk("model_count", 64'(count), 64'(q.size()));
    chk("model_valid", 64'(rd_valid), 64'(q.size() != 0));
    if (rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 64'(rd_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("head_pc",   64'(rd_pc),   64'(e.pc));
        chk("head_reg",  64'(rd_reg),  64'(e.rg));
        chk("head_data", 64'(rd_data), 64'(e.data));
      end
    end
    if (exp_push) q.push_back('{pc: wb_pc, rg: wb_reg, data: wb_data});
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc,
                    input bit exp_push);
    wb_en   = 1'b1;
    wb_reg  = r;
    wb_data = d;
    wb_pc   = pc;
    tick(exp_push);
    wb_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1'b0);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1'b0);
    stop = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    rd_ready = 1'b1;
    for (int i = 0; i < max_cycles && q.size() > 0; i++) tick(1'b0);
    rd_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0;
    stall = 1'b0; start = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_rd_pc", 64'(rd_pc), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    tick(1'b0);

    // Basic capture and in-order readout with rd_ready held high
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    rd_ready = 1'b1;
    wr(5'd3, 32'h11, 32'h10, 1'b1);
    chk("first_valid", 64'(rd_valid), 64'd1);
    chk("first_count", 64'(count), 64'd1);
    wr(5'd4, 32'h22, 32'h14, 1'b1);
    chk("pp_count", 64'(count), 64'd1);
    tick(1'b0);
    rd_ready = 1'b0;
    chk("basic_empty", 64'(count), 64'd0);
    pulse_stop();
    chk("stop_busy", 64'(busy), 64'd0);
    tick(1'b0);

    // start+stop together acts as stop; R0 writes are filtered
    start = 1'b1; stop = 1'b1;
    tick(1'b0);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 64'(busy), 64'd0);
    pulse_start();
    for (int i = 0; i < 3; i++) wr(5'd0, 32'hDEAD0000 + 32'(i), 32'h200 + 32'(4*i), 1'b0);
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_valid", 64'(rd_valid), 64'd0);
    pulse_stop();
    tick(1'b0);

    // Fill past full with STOP_ON_FULL: first 16 kept, overflow flagged, DONE
    pulse_start();
    for (int i = 0; i < 20; i++)
      wr(5'(i + 1), 32'h100 + 32'(i), 32'h1000 + 32'(4*i), i < 16);
    chk("full_count", 64'(count), 64'd16);
    chk("full_busy", 64'(busy), 64'd0);
    chk("full_overflow", 64'(overflow), 64'd1);
    pulse_start();
    chk("done_ignores_start", 64'(busy), 64'd0);
    drain(40);
    tick(1'b0);
    pulse_start();
    chk("idle_after_drain", 64'(busy), 64'd1);
    chk("overflow_cleared", 64'(overflow), 64'd0);

    // Full FIFO with simultaneous push and pop keeps count and takes the push
    for (int i = 0; i < 16; i++)
      wr(5'd7, 32'hA000 + 32'(i), 32'h2000 + 32'(4*i), 1'b1);
    chk("full2_count", 64'(count), 64'd16);
    chk("full2_busy", 64'(busy), 64'd1);
    rd_ready = 1'b1;
    wr(5'd9, 32'hBEEF, 32'h3000, 1'b1);
    rd_ready = 1'b0;
    chk("pushpop_full_count", 64'(count), 64'd16);
    chk("pushpop_full_ovf", 64'(overflow), 64'd0);
    drain(40);
    tick(1'b0);

    // Stall counting only while capturing
    pulse_start();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0);
    stall = 1'b0;
    pulse_stop();
    chk("stall_5", 64'(stall_cycles), 64'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    stall = 1'b0;
    chk("stall_outside", 64'(stall_cycles), 64'd5);

    // Reset mid-capture discards everything immediately
    pulse_start();
    for (int i = 0; i < 3; i++) wr(5'(10 + i), 32'h500 + 32'(i), 32'h4000 + 32'(4*i), 1'b1);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(rd_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_pc", 64'(rd_pc), 64'd0);
    chk("async_rst_data", 64'(rd_data), 64'd0);
    q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    tick(1'b0);
    pulse_start();
    stop = 1'b1;
    wr(5'd5, 32'h77, 32'h5000, 1'b1);
    stop = 1'b0;
    chk("post_rst_count", 64'(count), 64'd1);
    chk("stop_with_write_busy", 64'(busy), 64'd0);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
